// File: rtl/tawas_pkg.sv
// rtl/tawas_pkg.sv - shared constants for the Tawas thread scheduler
//
// Purpose: default thread count, PC width, minimum issue gap, and the
//          encodings of the scheduling mode input.
// Ports:   none (package).

package tawas_pkg;

   localparam int TAWAS_THREADS_DEF = 4;
   localparam int TAWAS_PC_W        = 24;
   localparam int TAWAS_MIN_GAP_DEF = 4;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_SKIP  = 1'b1;

endpackage

// File: rtl/tawas_rr_pick.sv
// rtl/tawas_rr_pick.sv - combinational round-robin first-set finder
//
// Purpose: find the first set bit of i_ready, scanning upward from i_start
//          and wrapping from THREADS-1 back to 0. Works for any THREADS,
//          including non-powers of two.
// Ports:
//   i_ready  [THREADS]  candidate mask
//   i_start  [SEL_W]    first index to examine (must be < THREADS)
//   o_found  1          some bit of i_ready is set
//   o_idx    [SEL_W]    winning index (i_start when nothing is found)

module tawas_rr_pick #(
   parameter int THREADS = 4,
   parameter int SEL_W   = $clog2(THREADS)
) (
   input  logic [THREADS-1:0] i_ready,
   input  logic [SEL_W-1:0]   i_start,
   output logic               o_found,
   output logic [SEL_W-1:0]   o_idx
);

   // One extra bit so start+offset never overflows before the wrap.
   logic [SEL_W:0] w_sum;

   always_comb begin
      o_found = 1'b0;
      o_idx   = i_start;
      w_sum   = '0;
      // Scan from the farthest offset down so the nearest hit wins.
      for (int k = THREADS - 1; k >= 0; k--) begin
         w_sum = {1'b0, i_start} + (SEL_W + 1)'(k);
         if (w_sum >= (SEL_W + 1)'(THREADS)) begin
            w_sum = w_sum - (SEL_W + 1)'(THREADS);
         end
         if (i_ready[w_sum[SEL_W-1:0]]) begin
            o_found = 1'b1;
            o_idx   = w_sum[SEL_W-1:0];
         end
      end
   end

endmodule

// File: rtl/tawas_thread_sched.sv
// rtl/tawas_thread_sched.sv - barrel thread scheduler with per-thread PCs
//
// Purpose: choose which hardware thread issues each cycle, in fixed barrel
//          rotation or skipping non-ready threads, while enforcing a minimum
//          gap between issues of the same thread. Holds one PC per thread.
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_mode_skip         0 = fixed rotation, 1 = skip non-ready threads
//   i_thread_en         per-thread run enable
//   i_thread_stall      per-thread stall
//   i_pc_upd_vld/sel    PC write strobe and target thread
//   i_pc_upd            new PC value
//   o_slice             thread presented this cycle
//   o_issue_vld         slot carries a real instruction
//   o_issue_pc          PC of the presented thread
//   o_idle              no thread enabled

module tawas_thread_sched
   import tawas_pkg::*;
#(
   parameter int              THREADS  = TAWAS_THREADS_DEF,
   parameter int              SEL_W    = $clog2(THREADS),
   parameter int              PC_W     = TAWAS_PC_W,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int              MIN_GAP  = TAWAS_MIN_GAP_DEF
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_mode_skip,
   input  logic [THREADS-1:0] i_thread_en,
   input  logic [THREADS-1:0] i_thread_stall,
   input  logic               i_pc_upd_vld,
   input  logic [SEL_W-1:0]   i_pc_upd_sel,
   input  logic [PC_W-1:0]    i_pc_upd,
   output logic [SEL_W-1:0]   o_slice,
   output logic               o_issue_vld,
   output logic [PC_W-1:0]    o_issue_pc,
   output logic               o_idle
);

   localparam int              CD_W    = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
   localparam logic [SEL_W-1:0] LAST   = SEL_W'(THREADS - 1);
   localparam logic [CD_W-1:0]  CD_LOAD = CD_W'(MIN_GAP - 1);

   logic [SEL_W-1:0]   r_slice;
   logic               r_issue_vld;
   logic [PC_W-1:0]    r_issue_pc;
   logic               r_idle;
   logic [PC_W-1:0]    r_pc [THREADS];
   logic [CD_W-1:0]    r_cd [THREADS];

   logic [THREADS-1:0] w_ready;
   logic [SEL_W-1:0]   w_start;
   logic               w_found;
   logic [SEL_W-1:0]   w_pick;
   logic [SEL_W-1:0]   w_cand;
   logic               w_issue;
   logic [PC_W-1:0]    w_next_pc;

   always_comb begin
      w_ready = '0;
      for (int i = 0; i < THREADS; i++) begin
         w_ready[i] = i_thread_en[i] & ~i_thread_stall[i] & (r_cd[i] == '0);
      end
   end

   assign w_start = (r_slice == LAST) ? '0 : r_slice + 1'b1;

   tawas_rr_pick #(
      .THREADS (THREADS),
      .SEL_W   (SEL_W)
   ) u_pick (
      .i_ready (w_ready),
      .i_start (w_start),
      .o_found (w_found),
      .o_idx   (w_pick)
   );

   always_comb begin
      w_cand  = w_start;
      w_issue = w_ready[w_start];
      if (i_mode_skip == MODE_SKIP) begin
         // Nothing ready: hold the pointer so the scan resumes from here.
         w_cand  = w_found ? w_pick : r_slice;
         w_issue = w_found;
      end
   end

   // PC mux with same-cycle bypass of an incoming write to the chosen thread.
   // An out-of-range update select never matches a candidate.
   always_comb begin
      w_next_pc = RESET_PC;
      for (int i = 0; i < THREADS; i++) begin
         if (w_cand == SEL_W'(i)) begin
            w_next_pc = r_pc[i];
         end
      end
      if (i_pc_upd_vld && (i_pc_upd_sel == w_cand)) begin
         w_next_pc = i_pc_upd;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_slice     <= LAST;
         r_issue_vld <= 1'b0;
         r_issue_pc  <= '0;
         r_idle      <= 1'b1;
         for (int i = 0; i < THREADS; i++) begin
            r_pc[i] <= RESET_PC;
            r_cd[i] <= '0;
         end
      end else begin
         r_slice     <= w_cand;
         r_issue_vld <= w_issue;
         r_issue_pc  <= w_next_pc;
         r_idle      <= (i_thread_en == '0);
         for (int i = 0; i < THREADS; i++) begin
            if (i_pc_upd_vld && (i_pc_upd_sel == SEL_W'(i))) begin
               r_pc[i] <= i_pc_upd;
            end
            // Counters run in both modes so switching modes keeps the gap.
            if (w_issue && (w_cand == SEL_W'(i))) begin
               r_cd[i] <= CD_LOAD;
            end else if (r_cd[i] != '0) begin
               r_cd[i] <= r_cd[i] - 1'b1;
            end
         end
      end
   end

   assign o_slice     = r_slice;
   assign o_issue_vld = r_issue_vld;
   assign o_issue_pc  = r_issue_pc;
   assign o_idle      = r_idle;

endmodule

// File: tb/tb_tawas_thread_sched.sv
// tb/tb_tawas_thread_sched.sv - directed-vector bench for tawas_thread_sched

module tb_tawas_thread_sched;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // 4-thread instance, MIN_GAP = 4
   logic        rst_n;
   logic        mode;
   logic [3:0]  en;
   logic [3:0]  stall;
   logic        uv;
   logic [1:0]  usel;
   logic [23:0] upd;
   logic [1:0]  slice;
   logic        vld;
   logic [23:0] pc;
   logic        idle;

   // 3-thread instance, MIN_GAP = 3, fixed mode
   logic        rst3_n;
   logic        mode3;
   logic [2:0]  en3;
   logic [2:0]  stall3;
   logic        uv3;
   logic [1:0]  usel3;
   logic [23:0] upd3;
   logic [1:0]  slice3;
   logic        vld3;
   logic [23:0] pc3;
   logic        idle3;

   tawas_thread_sched #(.THREADS(4), .MIN_GAP(4)) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_mode_skip    (mode),
      .i_thread_en    (en),
      .i_thread_stall (stall),
      .i_pc_upd_vld   (uv),
      .i_pc_upd_sel   (usel),
      .i_pc_upd       (upd),
      .o_slice        (slice),
      .o_issue_vld    (vld),
      .o_issue_pc     (pc),
      .o_idle         (idle)
   );

   tawas_thread_sched #(.THREADS(3), .MIN_GAP(3)) dut3 (
      .i_clk          (clk),
      .i_rst_n        (rst3_n),
      .i_mode_skip    (mode3),
      .i_thread_en    (en3),
      .i_thread_stall (stall3),
      .i_pc_upd_vld   (uv3),
      .i_pc_upd_sel   (usel3),
      .i_pc_upd       (upd3),
      .o_slice        (slice3),
      .o_issue_vld    (vld3),
      .o_issue_pc     (pc3),
      .o_idle         (idle3)
   );

   typedef struct packed {
      logic        mode;
      logic [3:0]  en;
      logic [3:0]  stall;
      logic        uv;
      logic [1:0]  usel;
      logic [23:0] upd;
      logic [1:0]  e_slice;
      logic        e_vld;
      logic [23:0] e_pc;
      logic        e_idle;
   } vec_t;

   vec_t tbl [24];
   int   n_checks = 0;
   int   n_errors = 0;

   function automatic vec_t mk(input logic m, input logic [3:0] e, input logic [3:0] s,
                               input logic u, input logic [1:0] us, input logic [23:0] up,
                               input logic [1:0] xs, input logic xv, input logic [23:0] xp,
                               input logic xi);
      vec_t v;
      v.mode = m; v.en = e; v.stall = s; v.uv = u; v.usel = us; v.upd = up;
      v.e_slice = xs; v.e_vld = xv; v.e_pc = xp; v.e_idle = xi;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic chk4(input string nm, input logic [1:0] xs, input logic xv,
                       input logic [23:0] xp, input logic xi);
      chk({nm, ".slice"}, 32'(slice), 32'(xs));
      chk({nm, ".vld"},   32'(vld),   32'(xv));
      chk({nm, ".pc"},    32'(pc),    32'(xp));
      chk({nm, ".idle"},  32'(idle),  32'(xi));
   endtask

   task automatic chk3(input string nm, input logic [1:0] xs, input logic xv,
                       input logic [23:0] xp, input logic xi);
      chk({nm, ".slice"}, 32'(slice3), 32'(xs));
      chk({nm, ".vld"},   32'(vld3),   32'(xv));
      chk({nm, ".pc"},    32'(pc3),    32'(xp));
      chk({nm, ".idle"},  32'(idle3),  32'(xi));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [1:0] seq_s [6];
      logic       seq_v [6];

      //           mode en    stall uv sel upd        slice vld pc         idle
      tbl[0]  = mk(1'b0, 4'hF, 4'h0, 0, 0, 24'h0,     0, 1, 24'h0,     0);
      tbl[1]  = mk(1'b0, 4'hF, 4'h0, 0, 0, 24'h0,     1, 1, 24'h0,     0);
      tbl[2]  = mk(1'b0, 4'hF, 4'h0, 0, 0, 24'h0,     2, 1, 24'h0,     0);
      tbl[3]  = mk(1'b0, 4'hF, 4'h0, 0, 0, 24'h0,     3, 1, 24'h0,     0);
      tbl[4]  = mk(1'b0, 4'hF, 4'h4, 0, 0, 24'h0,     0, 1, 24'h0,     0);
      tbl[5]  = mk(1'b0, 4'hF, 4'h4, 0, 0, 24'h0,     1, 1, 24'h0,     0);
      tbl[6]  = mk(1'b0, 4'hF, 4'h4, 0, 0, 24'h0,     2, 0, 24'h0,     0);
      tbl[7]  = mk(1'b0, 4'hF, 4'h4, 0, 0, 24'h0,     3, 1, 24'h0,     0);
      tbl[8]  = mk(1'b0, 4'hF, 4'h0, 0, 0, 24'h0,     0, 1, 24'h0,     0);
      tbl[9]  = mk(1'b0, 4'hF, 4'h0, 1, 1, 24'h100,   1, 1, 24'h100,   0);
      tbl[10] = mk(1'b0, 4'hF, 4'h0, 1, 3, 24'h300,   2, 1, 24'h0,     0);
      tbl[11] = mk(1'b0, 4'hF, 4'h0, 0, 0, 24'h0,     3, 1, 24'h300,   0);
      tbl[12] = mk(1'b0, 4'hF, 4'h0, 0, 0, 24'h0,     0, 1, 24'h0,     0);
      tbl[13] = mk(1'b0, 4'hF, 4'h0, 0, 0, 24'h0,     1, 1, 24'h100,   0);
      tbl[14] = mk(1'b1, 4'h5, 4'h0, 0, 0, 24'h0,     2, 1, 24'h0,     0);
      tbl[15] = mk(1'b1, 4'h5, 4'h0, 0, 0, 24'h0,     2, 0, 24'h0,     0);
      tbl[16] = mk(1'b1, 4'h5, 4'h0, 0, 0, 24'h0,     0, 1, 24'h0,     0);
      tbl[17] = mk(1'b1, 4'h5, 4'h0, 0, 0, 24'h0,     0, 0, 24'h0,     0);
      tbl[18] = mk(1'b1, 4'h5, 4'h0, 0, 0, 24'h0,     2, 1, 24'h0,     0);
      tbl[19] = mk(1'b1, 4'h5, 4'h0, 0, 0, 24'h0,     2, 0, 24'h0,     0);
      tbl[20] = mk(1'b1, 4'h5, 4'h0, 0, 0, 24'h0,     0, 1, 24'h0,     0);
      tbl[21] = mk(1'b1, 4'h5, 4'h0, 0, 0, 24'h0,     0, 0, 24'h0,     0);
      tbl[22] = mk(1'b1, 4'h0, 4'h0, 0, 0, 24'h0,     0, 0, 24'h0,     1);
      tbl[23] = mk(1'b0, 4'hF, 4'h0, 0, 0, 24'h0,     1, 1, 24'h100,   0);

      seq_s[0] = 0; seq_v[0] = 1;
      seq_s[1] = 2; seq_v[1] = 1;
      seq_s[2] = 2; seq_v[2] = 0;
      seq_s[3] = 2; seq_v[3] = 0;
      seq_s[4] = 0; seq_v[4] = 1;
      seq_s[5] = 2; seq_v[5] = 1;

      rst_n = 1'b1; mode = 1'b0; en = '0; stall = '0; uv = 1'b0; usel = '0; upd = '0;
      rst3_n = 1'b1; mode3 = 1'b0; en3 = '0; stall3 = '0; uv3 = 1'b0; usel3 = '0; upd3 = '0;
      #2;
      rst_n = 1'b0;
      rst3_n = 1'b0;
      step();
      step();
      chk4("reset", 2'd3, 1'b0, 24'h0, 1'b1);
      rst_n = 1'b1;

      // Table: fixed rotation, stall bubble, PC write/bypass, skip mode, idle
      for (int i = 0; i < 24; i++) begin
         mode  = tbl[i].mode;
         en    = tbl[i].en;
         stall = tbl[i].stall;
         uv    = tbl[i].uv;
         usel  = tbl[i].usel;
         upd   = tbl[i].upd;
         step();
         chk4($sformatf("vec%0d", i), tbl[i].e_slice, tbl[i].e_vld, tbl[i].e_pc, tbl[i].e_idle);
      end

      // Mid-run reset in skip mode with live cooldowns and a written PC[0]
      mode = 1'b1; en = 4'h5; stall = '0;
      uv = 1'b1; usel = 2'd0; upd = 24'h000555;
      step();
      uv = 1'b0;
      step();
      #2;
      rst_n = 1'b0;
      #1;
      chk4("async_rst", 2'd3, 1'b0, 24'h0, 1'b1);
      step();
      chk4("rst_hold", 2'd3, 1'b0, 24'h0, 1'b1);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         chk4($sformatf("skip%0d", i), seq_s[i], seq_v[i], 24'h0, 1'b0);
      end

      // Three threads: wrap 2 -> 0, out-of-range PC select ignored, idle
      rst3_n = 1'b1;
      en3 = 3'h7; uv3 = 1'b1; usel3 = 2'd3; upd3 = 24'h000ABC;
      step();
      chk3("t3_0", 2'd0, 1'b1, 24'h0, 1'b0);
      step();
      chk3("t3_1", 2'd1, 1'b1, 24'h0, 1'b0);
      step();
      chk3("t3_2", 2'd2, 1'b1, 24'h0, 1'b0);
      step();
      chk3("t3_3", 2'd0, 1'b1, 24'h0, 1'b0);
      uv3 = 1'b0;
      en3 = 3'h0;
      step();
      chk3("t3_off", 2'd1, 1'b0, 24'h0, 1'b1);
      en3 = 3'h7;
      step();
      chk3("t3_on", 2'd2, 1'b1, 24'h0, 1'b0);
      step();
      chk3("t3_pc0", 2'd0, 1'b1, 24'h0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
